// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, press/release/held/long-press outputs.
// Define BUTTON_AUTOREPEAT_EN to re-issue `debounced` every REPEAT_CYCLES while in the long-press state.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic debounced,
  output logic released,
  output logic held,
  output logic long_press
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    PRESSED    = 3'd2,
    LONG       = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  localparam logic [31:0] DB_LAST   = DEBOUNCE_CYCLES - 32'd1;
  localparam logic [31:0] LONG_LAST = LONG_CYCLES - 32'd1;

  if ((DEBOUNCE_CYCLES < 32'd2) || (LONG_CYCLES < 32'd2) || (REPEAT_CYCLES < 32'd2)) begin : g_param_check
    $error("button_conditioner: cycle parameters must be >= 2");
  end

  state_t      state_r;
  logic        from_long_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        pressed_s;
  logic [31:0] db_cnt_r;
  logic [31:0] hold_cnt_r;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [31:0] REP_LAST = REPEAT_CYCLES - 32'd1;
  logic [31:0] rep_cnt_r;
`endif

  // btn is active-low; the synchroniser resets to the released level
  assign pressed_s = ~sync2_r;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce / hold FSM with registered pulse and level outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      from_long_r <= 1'b0;
      db_cnt_r    <= 32'd0;
      hold_cnt_r  <= 32'd0;
`ifdef BUTTON_AUTOREPEAT_EN
      rep_cnt_r   <= 32'd0;
`endif
      debounced   <= 1'b0;
      released    <= 1'b0;
      held        <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      debounced  <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pressed_s) begin
            state_r  <= PRESS_DB;
            db_cnt_r <= 32'd0;
          end else begin
            state_r  <= IDLE;
          end
        end
        PRESS_DB: begin
          // the entry cycle is the first stable sample, so accept on the incremented count
          if (!pressed_s) begin
            state_r  <= IDLE;
            db_cnt_r <= 32'd0;
          end else if ((db_cnt_r + 32'd1) == DB_LAST) begin
            state_r    <= PRESSED;
            db_cnt_r   <= 32'd0;
            hold_cnt_r <= 32'd0;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt_r  <= 32'd0;
`endif
            debounced  <= 1'b1;
            held       <= 1'b1;
          end else begin
            db_cnt_r <= db_cnt_r + 32'd1;
          end
        end
        PRESSED: begin
          // release is tested first so it wins over a coincident long-press
          if (!pressed_s) begin
            state_r     <= RELEASE_DB;
            from_long_r <= 1'b0;
            db_cnt_r    <= 32'd0;
          end else if (hold_cnt_r == LONG_LAST) begin
            state_r    <= LONG;
            hold_cnt_r <= hold_cnt_r + 32'd1;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt_r  <= 32'd0;
`endif
            long_press <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + 32'd1;
          end
        end
        LONG: begin
          if (!pressed_s) begin
            state_r     <= RELEASE_DB;
            from_long_r <= 1'b1;
            db_cnt_r    <= 32'd0;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (rep_cnt_r == REP_LAST) begin
            rep_cnt_r <= 32'd0;
            debounced <= 1'b1;
          end else begin
            rep_cnt_r <= rep_cnt_r + 32'd1;
          end
`else
          else begin
            state_r <= LONG;
          end
`endif
        end
        RELEASE_DB: begin
          // a returning press resumes the originating state with counters untouched
          if (pressed_s) begin
            state_r  <= from_long_r ? LONG : PRESSED;
            db_cnt_r <= 32'd0;
          end else if ((db_cnt_r + 32'd1) == DB_LAST) begin
            state_r    <= IDLE;
            db_cnt_r   <= 32'd0;
            hold_cnt_r <= 32'd0;
            released   <= 1'b1;
            held       <= 1'b0;
          end else begin
            db_cnt_r <= db_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          db_cnt_r <= 32'd0;
          held     <= 1'b0;
        end
      endcase
    end
  end

endmodule
